// File: rtl/fe_fetch_q.sv
// rtl/fe_fetch_q.sv - fetch sequencer and in-order instruction queue ahead of fe_buf
// Out-of-order fe_buf returns are parked per slot and drained to decode in program order.
package fe_fetch_q_pkg;
  localparam int RV_INSTR_WIDTH = 32;
  typedef logic [31:0] t_paddr;
  typedef logic [3:0]  t_mem_id;

  typedef struct packed {
    logic       valid;
    t_mem_id    id;
    t_paddr     addr;
    logic [1:0] kind;
  } t_fe_fb_req;

  typedef struct packed {
    logic                      valid;
    t_mem_id                   id;
    logic [RV_INSTR_WIDTH-1:0] instr;
  } t_fb_fe_rsp;
endpackage

module fe_fetch_q
  import fe_fetch_q_pkg::*;
#(
  parameter int     DEPTH    = 8,
  parameter t_paddr RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        fe_enable,
  input  logic                        br_fe_redirect_valid,
  input  t_paddr                      br_fe_redirect_pc,
  output t_fe_fb_req                  fe_fb_req_fb0,
  input  t_fb_fe_rsp                  fb_fe_rsp_nnn,
  output logic                        fe_de_valid_nnn,
  output logic [RV_INSTR_WIDTH-1:0]   fe_de_instr_nnn,
  output t_paddr                      fe_de_pc_nnn,
  input  logic                        de_fe_stall_nnn,
  output logic [$clog2(DEPTH):0]      fe_occ_nnn
);
  localparam int LG = $clog2(DEPTH);

  typedef enum logic [1:0] {FREE, PEND, DONE, STALE} t_slot_st;

  t_slot_st                  r_st     [DEPTH];
  t_slot_st                  w_st_nxt [DEPTH];
  t_paddr                    r_pc     [DEPTH];
  logic [RV_INSTR_WIDTH-1:0] r_instr  [DEPTH];
  logic [LG-1:0]             r_head;
  logic [LG-1:0]             r_tail;
  t_paddr                    r_fetch_pc;
  t_fe_fb_req                r_req;
  logic [LG:0]               r_occ;
  logic [LG:0]               w_occ_nxt;

  logic          w_issue;
  logic          w_accept;
  logic          w_rsp_fill;
  logic [LG-1:0] w_rsp_slot;
  t_paddr        w_pc_nxt;

  always_comb begin
    w_issue    = fe_enable & (r_st[r_tail] == FREE);
    w_pc_nxt   = br_fe_redirect_valid ? br_fe_redirect_pc : r_fetch_pc;
    w_rsp_slot = fb_fe_rsp_nnn.id[LG-1:0];
    w_rsp_fill = fb_fe_rsp_nnn.valid & (r_st[w_rsp_slot] == PEND) & ~br_fe_redirect_valid;
    w_accept   = (r_st[r_head] == DONE) & ~de_fe_stall_nnn & ~br_fe_redirect_valid;
  end

  // Later terms override earlier ones; issue/accept never collide with a legal return.
  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_st_nxt[i] = r_st[i];
      if (br_fe_redirect_valid) begin
        case (r_st[i])
          PEND:    w_st_nxt[i] = STALE;
          DONE:    w_st_nxt[i] = FREE;
          default: w_st_nxt[i] = r_st[i];
        endcase
      end
      if (fb_fe_rsp_nnn.valid && (w_rsp_slot == LG'(i))) begin
        if (r_st[i] == PEND)
          w_st_nxt[i] = br_fe_redirect_valid ? FREE : DONE;
        else if (r_st[i] == STALE)
          w_st_nxt[i] = FREE;
      end
      if (w_accept && (r_head == LG'(i)))
        w_st_nxt[i] = FREE;
      if (w_issue && (r_tail == LG'(i)))
        w_st_nxt[i] = PEND;
      w_occ_nxt = w_occ_nxt + (LG+1)'(w_st_nxt[i] != FREE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_st[i]    <= FREE;
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
      r_head     <= '0;
      r_tail     <= '0;
      r_fetch_pc <= RESET_PC;
      r_req      <= '0;
      r_occ      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        r_st[i] <= w_st_nxt[i];
      if (w_issue)
        r_pc[r_tail] <= w_pc_nxt;
      if (w_rsp_fill)
        r_instr[w_rsp_slot] <= fb_fe_rsp_nnn.instr;
      r_occ <= w_occ_nxt;

      r_req <= '0;
      if (w_issue) begin
        r_req.valid <= 1'b1;
        r_req.id    <= t_mem_id'(r_tail);
        r_req.addr  <= w_pc_nxt;
        r_tail      <= r_tail + LG'(1);
        r_fetch_pc  <= w_pc_nxt + 32'd4;
      end else if (br_fe_redirect_valid) begin
        r_fetch_pc <= br_fe_redirect_pc;
      end

      // Head lands on the slot taking the redirect target, so that target is delivered.
      if (br_fe_redirect_valid)
        r_head <= r_tail;
      else if (w_accept)
        r_head <= r_head + LG'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && fb_fe_rsp_nnn.valid) begin
      assert ((r_st[w_rsp_slot] == PEND) || (r_st[w_rsp_slot] == STALE));
      assert ((fb_fe_rsp_nnn.id >> LG) == '0);
    end
  end

  assign fe_fb_req_fb0   = r_req;
  assign fe_de_valid_nnn = (r_st[r_head] == DONE);
  assign fe_de_instr_nnn = r_instr[r_head];
  assign fe_de_pc_nnn    = r_pc[r_head];
  assign fe_occ_nnn      = r_occ;
endmodule
